// File: rtl/calc_host_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_host_seq (with package cmd_bits)                        |
// | Description : Request/response sequencer for the calculator device FSM.    |
// |               Accepts a whole request (command, operand 1, operand 2)      |
// |               with one valid/ready handshake, replays it to the device     |
// |               as a cycle-exact cs/din write burst, waits for the result    |
// |               of read (b_tx) commands and returns exactly one response.    |
// | Ports       : clk, rst                 clock, async active-high reset      |
// |               req_valid/ready          request handshake                   |
// |               req_cmd/op1/op2          request payload                     |
// |               rsp_valid/ready          response handshake                  |
// |               rsp_data/rsp_err         captured result / timeout flag      |
// |               dev_busy,dev_dout,drdy   from the device                     |
// |               dev_cs, dev_din          to the device                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

// Command byte bit positions shared with the calculator device.
package cmd_bits;
   localparam int b_tx     = 0;
   localparam int b_op_2   = 1;
   localparam int b_addop  = 2;
   localparam int b_subop  = 3;
   localparam int b_addres = 4;
   localparam int b_subres = 5;
endpackage

module calc_host_seq
   import cmd_bits::*;
#(
   parameter int DW         = 8,
   parameter int TMO_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_cmd,
   input  logic [DW-1:0] req_op1,
   input  logic [DW-1:0] req_op2,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   input  logic          dev_busy,
   output logic          dev_cs,
   output logic [DW-1:0] dev_din,
   input  logic [DW-1:0] dev_dout,
   input  logic          dev_drdy
);

   localparam int           CW       = $clog2(TMO_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_BUSY = 3'd1,
      CMD       = 3'd2,
      OP1       = 3'd3,
      OP2       = 3'd4,
      WAIT_RDY  = 3'd5,
      RESP      = 3'd6
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   state_t          w_ops_done;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [DW-1:0]   r_cmd;
   logic [DW-1:0]   r_op1;
   logic [DW-1:0]   r_op2;
   logic [DW-1:0]   w_data_nxt;
   logic            w_err_nxt;
   logic            w_latch;
   logic            w_has_op1;
   logic            w_has_op2;

   // Operand 1 is only sent for the arithmetic commands; operand 2 has its own bit.
   assign w_has_op1  = r_cmd[b_addop] | r_cmd[b_subop] | r_cmd[b_addres] | r_cmd[b_subres];
   assign w_has_op2  = r_cmd[b_op_2];
   // Where the burst goes once the last byte has been written.
   assign w_ops_done = r_cmd[b_tx] ? WAIT_RDY : RESP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_cmd    <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         rsp_data <= w_data_nxt;
         rsp_err  <= w_err_nxt;
         if (w_latch) begin
            r_cmd <= req_cmd;
            r_op1 <= req_op1;
            r_op2 <= req_op2;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = rsp_data;
      w_err_nxt   = rsp_err;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               // Response defaults to "no data, no error"; only the wait
               // states overwrite it.
               w_latch     = 1'b1;
               w_cnt_nxt   = '0;
               w_data_nxt  = '0;
               w_err_nxt   = 1'b0;
               w_state_nxt = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!dev_busy) begin
               w_state_nxt = CMD;
            end else if (r_cnt == CNT_LAST) begin
               w_data_nxt  = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         CMD: begin
            // Restart the timeout budget for a possible WAIT_RDY phase.
            w_cnt_nxt = '0;
            if (w_has_op1) begin
               w_state_nxt = OP1;
            end else if (w_has_op2) begin
               w_state_nxt = OP2;
            end else begin
               w_state_nxt = w_ops_done;
            end
         end
         OP1: begin
            w_state_nxt = w_has_op2 ? OP2 : w_ops_done;
         end
         OP2: begin
            w_state_nxt = w_ops_done;
         end
         WAIT_RDY: begin
            // A result arriving on the last budget cycle still wins.
            if (dev_drdy) begin
               w_data_nxt  = dev_dout;
               w_err_nxt   = 1'b0;
               w_state_nxt = RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_data_nxt  = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Handshake and device outputs decode only from state and latched request.
   assign req_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign dev_cs    = (r_state == CMD);

   always_comb begin
      dev_din = '0;
      case (r_state)
         CMD:     dev_din = r_cmd;
         OP1:     dev_din = r_op1;
         OP2:     dev_din = r_op2;
         default: dev_din = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/calc_host_seq.md
Name: calc_host_seq

Overview:
- Upstream sequencer that drives the calculator device FSM (dev_fsm) over its cs/din/dout/drdy/busy port.
- Accepts one whole calculator request per handshake: command byte, operand 1, operand 2.
- Issues the cycle-exact write sequence the device expects, collects the result of read (b_tx) commands, and returns exactly one response per request.
- Gives host logic a clean valid/ready interface in place of bit-banged transactions.

Parameters:
- DW, 8, data/command width; must match dev_fsm DW.
- TMO_CYCLES, 16, maximum cycles spent waiting for busy low or for drdy before aborting with an error (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  sequencer can accept a request.
- req_cmd  in  DW  command byte; bit positions from the cmd_bits package.
- req_op1  in  DW  operand 1.
- req_op2  in  DW  operand 2.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DW  captured dev dout; 0 for non-read commands or on error.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- dev_busy  in  1  device busy.
- dev_cs  out  1  device chip select.
- dev_din  out  DW  device data-in bus.
- dev_dout  in  DW  device result.
- dev_drdy  in  1  device result valid.

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; dev_cs=0; dev_din=0; timeout counter=0; latched request regs=0.
- States: IDLE, WAIT_BUSY, CMD, OP1, OP2, WAIT_RDY, RESP.
- All outputs are registered or decoded from state plus latched regs only. No combinational path from any input to any output.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cmd/op1/op2, clear counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If !dev_busy, go to CMD.
  - Otherwise increment counter. When counter reaches TMO_CYCLES-1, go to RESP with err=1.
- CMD (exactly 1 cycle): dev_cs=1, dev_din=cmd. Next state:
  - OP1 if any of b_addop, b_subop, b_addres, b_subres is set;
  - else OP2 if b_op_2 is set;
  - else WAIT_RDY if b_tx is set;
  - else RESP.
- OP1 (1 cycle): dev_cs=0, dev_din=op1. Next state is OP2 if b_op_2, else WAIT_RDY if b_tx, else RESP.
- OP2 (1 cycle): dev_din=op2. Next state is WAIT_RDY if b_tx, else RESP. Counter is cleared on entry to WAIT_RDY.
- WAIT_RDY:
  - dev_din=0.
  - If dev_drdy: capture dev_dout into rsp_data, err=0, go to RESP. drdy takes priority over timeout in the same cycle.
  - Otherwise, when counter reaches TMO_CYCLES-1: rsp_data=0, err=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable.
  - On rsp_ready, go to IDLE. req_ready returns to 1 the following cycle; there is no IDLE bypass.
- dev_cs and dev_din are 0 in IDLE, WAIT_BUSY, WAIT_RDY and RESP.
- Non-read commands produce a response with rsp_data=0, err=0.
- Latency from accept edge to rsp_valid, busy low, no tx:
  - 2 edges plus 1 per operand phase.
  - Example: op_2-only takes 3 edges; addop+op_2 takes 4.
- Reset mid-operation: dev_cs is deasserted at once, any pending response is dropped, and the sequencer restarts in IDLE.
- The command byte is sent unmodified, including bits the sequencer does not interpret.

Test Plan (DW=8, TMO_CYCLES=16; real dev_fsm unless stated):
- Request cmd=(1<<b_op_2), op2=8'h05:
  - dev_cs high exactly 1 cycle with dev_din=cmd;
  - next cycle dev_din=8'h05;
  - rsp_valid 3 edges after accept, rsp_data=0, rsp_err=0.
- Request cmd=(1<<b_op_2)|(1<<b_addop), op1=8'h12, op2=8'h34, then request cmd=(1<<b_tx) -> second response rsp_data=8'h46, rsp_err=0.
- Behavioural device model holds dev_busy high for 3 cycles after accept -> dev_cs rises only in the cycle after dev_busy is sampled low; no din phase is skipped.
- Request cmd=(1<<b_tx) with dev_drdy tied 0 -> after 16 cycles in WAIT_RDY: rsp_valid=1, rsp_err=1, rsp_data=0; the next request completes normally.
- rsp_ready held 0 for 5 cycles with req_valid=1 -> rsp_valid/rsp_data stable, req_ready=0, no new dev_cs pulse; on rsp_ready=1 the queued request is accepted the following cycle.
- rst pulsed during OP1 of an addop request -> dev_cs=0 and dev_din=0 immediately, no response emitted, req_ready=1 after release.
